block_collision_check: RTL and testbench

//   Reads the 20x20 playfield bitmap and tests a candidate 4x4 block placement

---
 rtl/tetris_pkg.sv | 24 ++
 rtl/block_collision_check.sv | 129 ++++++++++++
 tb/tb_block_collision_check.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/tetris_pkg.sv
// Shared playfield constants and collision-checker state encoding.
// The field writer and the game FSM use the same geometry and state values.
//   FIELD_W / FIELD_H : playfield size in cells; field bit = row*FIELD_W + col
//   BLK               : block matrix edge; matrix bit i = (row i/BLK, col i%BLK)
//   FIELD_BITS        : width of the flat playfield bitmap
//   IDLE / SCAN / DONE: 2-bit state encoding of the collision checker
package tetris_pkg;

  localparam int FIELD_W    = 20;
  localparam int FIELD_H    = 20;
  localparam int BLK        = 4;
  localparam int FIELD_BITS = 400;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = IDLE,
    S_SCAN = SCAN,
    S_DONE = DONE
  } chk_state_t;

endpackage

// File: rtl/block_collision_check.sv
// Sequential collision test of a 4x4 candidate block against the playfield.
// One block cell is evaluated per clock through a single shared field mux,
// so a check always takes 16 scan cycles followed by one DONE cycle.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; results of the last check are held
// SCAN  | evaluating cell idx (0..15), one per clock
// DONE  | done pulse cycle; returns to IDLE on the next edge
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   synchronous active-low reset
//   start        in   request a check (ignored while busy)
//   cand_x       in   [4:0]   candidate column
//   cand_y       in   [4:0]   candidate row
//   cand_matrix  in   [15:0]  candidate cells, bit 0 = top-left
//   field        in   [399:0] playfield bitmap, must be stable while busy
//   busy         out  check in progress
//   done         out  one-cycle completion pulse
//   collide      out  any set cell overlaps the field or is out of bounds
//   oob          out  any set cell is out of bounds
//   hit_mask     out  [15:0] per-cell hit flags
module block_collision_check
  import tetris_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4:0]            cand_x,
  input  logic [4:0]            cand_y,
  input  logic [15:0]           cand_matrix,
  input  logic [FIELD_BITS-1:0] field,
  output logic                  busy,
  output logic                  done,
  output logic                  collide,
  output logic                  oob,
  output logic [15:0]           hit_mask
);

  chk_state_t state, state_nxt;

  logic [4:0]  x_q, y_q;
  logic [15:0] m_q;
  logic [3:0]  idx;

  logic [5:0]  px, py;
  logic        cell_in;
  logic [8:0]  fidx;
  logic        field_bit;
  logic        cell_hit;
  logic        cell_oob;

  // Cell evaluation. Coordinates are widened to 6 bits so x=31 plus col=3
  // reads as 34 (out of bounds) instead of wrapping back into the field.
  always_comb begin
    px        = {1'b0, x_q} + {4'b0, idx[1:0]};
    py        = {1'b0, y_q} + {4'b0, idx[3:2]};
    cell_in   = (px < 6'(FIELD_W)) && (py < 6'(FIELD_H));
    fidx      = 9'd0;
    field_bit = 1'b0;
    if (cell_in) begin
      fidx      = {4'b0, py[4:0]} * 9'(FIELD_W) + {4'b0, px[4:0]};
      field_bit = field[fidx];
    end
    cell_hit  = m_q[idx] & (~cell_in | field_bit);
    cell_oob  = m_q[idx] & ~cell_in;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start)        state_nxt = S_SCAN;
      S_SCAN:  if (idx == 4'd15) state_nxt = S_DONE;
      S_DONE:                    state_nxt = S_IDLE;
      default:                   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      collide  <= 1'b0;
      oob      <= 1'b0;
      hit_mask <= 16'h0000;
      idx      <= 4'd0;
      x_q      <= 5'd0;
      y_q      <= 5'd0;
      m_q      <= 16'h0000;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            x_q      <= cand_x;
            y_q      <= cand_y;
            m_q      <= cand_matrix;
            collide  <= 1'b0;
            oob      <= 1'b0;
            hit_mask <= 16'h0000;
            idx      <= 4'd0;
            busy     <= 1'b1;
          end
        end
        S_SCAN: begin
          hit_mask[idx] <= cell_hit;
          collide       <= collide | cell_hit;
          oob           <= oob | cell_oob;
          idx           <= idx + 4'd1;
          if (idx == 4'd15) done <= 1'b1;
        end
        S_DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
        end
        default: begin
          done <= 1'b0;
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_block_collision_check.sv
module tb_block_collision_check;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [4:0]   cand_x, cand_y;
  logic [15:0]  cand_matrix;
  logic [399:0] field;
  logic         busy, done, collide, oob;
  logic [15:0]  hit_mask;

  int errors = 0;
  int checks = 0;

  block_collision_check dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .cand_x      (cand_x),
    .cand_y      (cand_y),
    .cand_matrix (cand_matrix),
    .field       (field),
    .busy        (busy),
    .done        (done),
    .collide     (collide),
    .oob         (oob),
    .hit_mask    (hit_mask)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete check. pulse_at: scan cycle in which start is re-asserted
  // (-1 = never). scramble: corrupt cand_* right after acceptance.
  task automatic run_check(input string tag, input logic [4:0] x, input logic [4:0] y,
                           input logic [15:0] m, input logic ec, input logic eo,
                           input logic [15:0] em, input int pulse_at, input bit scramble);
    int n;
    bit seen;
    cand_x = x;
    cand_y = y;
    cand_matrix = m;
    start = 1'b1;
    tick();                       // edge k
    start = 1'b0;
    chk({tag, " busy@k"}, 32'(busy), 32'd1);
    chk({tag, " done@k"}, 32'(done), 32'd0);
    if (scramble) begin
      cand_x = ~x;
      cand_y = ~y;
      cand_matrix = ~m;
    end
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      start = (n == pulse_at);
      tick();
      n++;
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    chk({tag, " latency"}, 32'(n), 32'd16);
    chk({tag, " collide"}, 32'(collide), 32'(ec));
    chk({tag, " oob"}, 32'(oob), 32'(eo));
    chk({tag, " hit_mask"}, 32'(hit_mask), 32'(em));
    tick();                       // edge k+17
    chk({tag, " done@k+17"}, 32'(done), 32'd0);
    chk({tag, " busy@k+17"}, 32'(busy), 32'd0);
    tick();
    tick();
    chk({tag, " collide held"}, 32'(collide), 32'(ec));
    chk({tag, " hit_mask held"}, 32'(hit_mask), 32'(em));
  endtask

  initial begin
    int ndone;
    bit exp_done;
    rst_n = 1'b0;
    start = 1'b1;                 // reset must win over start
    cand_x = 5'd0;
    cand_y = 5'd0;
    cand_matrix = 16'h000F;
    field = '0;
    tick();
    tick();
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset collide", 32'(collide), 32'd0);
    chk("reset oob", 32'(oob), 32'd0);
    chk("reset hit_mask", 32'(hit_mask), 32'd0);
    start = 1'b0;
    rst_n = 1'b1;
    tick();

    // 1. empty field, top row
    run_check("t1", 5'd0, 5'd0, 16'h000F, 1'b0, 1'b0, 16'h0000, -1, 1'b0);

    // 2. single occupied cell at (1,1)
    field[21] = 1'b1;
    run_check("t2 hit", 5'd0, 5'd0, 16'h0020, 1'b1, 1'b0, 16'h0020, -1, 1'b0);
    run_check("t2 miss", 5'd0, 5'd0, 16'h0010, 1'b0, 1'b0, 16'h0000, -1, 1'b0);
    run_check("t2 scrambled", 5'd0, 5'd0, 16'h0020, 1'b1, 1'b0, 16'h0020, -1, 1'b1);
    field = '0;

    // 3. bounds corners
    run_check("t3 out", 5'd17, 5'd17, 16'h8000, 1'b1, 1'b1, 16'h8000, -1, 1'b0);
    run_check("t3 corner", 5'd19, 5'd19, 16'h0001, 1'b0, 1'b0, 16'h0000, -1, 1'b0);

    // 4. no 5-bit wraparound; empty matrix never collides
    run_check("t4 wrap", 5'd31, 5'd0, 16'h0008, 1'b1, 1'b1, 16'h0008, -1, 1'b0);
    run_check("t4 empty", 5'd31, 5'd31, 16'h0000, 1'b0, 1'b0, 16'h0000, -1, 1'b0);

    // 5a. start pulse while scanning is ignored
    run_check("t5 ignore", 5'd17, 5'd17, 16'h8000, 1'b1, 1'b1, 16'h8000, 5, 1'b0);

    // 5b. reset mid-scan aborts with no done
    field[21] = 1'b1;
    cand_x = 5'd0;
    cand_y = 5'd0;
    cand_matrix = 16'h0020;
    start = 1'b1;
    tick();                       // edge k
    start = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t5 abort busy", 32'(busy), 32'd0);
    chk("t5 abort done", 32'(done), 32'd0);
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done) ndone++;
    end
    chk("t5 abort no done", 32'(ndone), 32'd0);
    run_check("t5 after reset", 5'd0, 5'd0, 16'h0020, 1'b1, 1'b0, 16'h0020, -1, 1'b0);
    field = '0;

    // 6. start held: one check per 18 cycles
    cand_x = 5'd0;
    cand_y = 5'd0;
    cand_matrix = 16'h000F;
    start = 1'b1;
    ndone = 0;
    for (int n = 0; n < 60; n++) begin
      tick();                     // n = 0 is edge k
      exp_done = (n == 16) || (n == 34) || (n == 52);
      if (done) ndone++;
      chk($sformatf("t6 done@k+%0d", n), 32'(done), 32'(exp_done));
    end
    start = 1'b0;
    chk("t6 pulse count", 32'(ndone), 32'd3);
    for (int i = 0; i < 20; i++) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
